// File: rtl/seven_seg_scan.sv
// Scan controller for a multiplexed common-anode seven-segment display.
// Host writes land in a shadow register and move to the display register only at frame boundaries.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              seg_digit,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow_val;
  logic [NUM_DIGITS-1:0]     r_shadow_blank;
  logic [4*NUM_DIGITS-1:0]   r_disp_val;
  logic [NUM_DIGITS-1:0]     r_disp_blank;
  logic                      r_pending;

  logic                      w_slot_end;
  logic                      w_frame_end;
  logic                      w_guard_done;
  logic [3:0]                w_nibble [NUM_DIGITS];

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  // A zero-length guard would make the compare trivially true, so it is elided.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_guard_done = 1'b1;
    end else begin : g_guard
      assign w_guard_done = (r_cnt >= CW'(GUARD_CYCLES));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibble[gi] = r_disp_val[4*gi +: 4];
      assign an_out[gi]   = ~((r_idx == IW'(gi)) && w_guard_done && !r_disp_blank[gi]);
    end
  endgenerate

  assign seg_digit  = w_nibble[r_idx];
  assign pending    = r_pending;
  assign frame_done = w_frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shadow_val   <= '0;
      r_shadow_blank <= '0;
      r_disp_val     <= '0;
      r_disp_blank   <= '1;
      r_pending      <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A load on the boundary itself bypasses the shadow so it is shown next frame.
      if (w_frame_end) begin
        if (load) begin
          r_disp_val     <= value_in;
          r_disp_blank   <= blank_in;
          r_shadow_val   <= value_in;
          r_shadow_blank <= blank_in;
          r_pending      <= 1'b0;
        end else if (r_pending) begin
          r_disp_val   <= r_shadow_val;
          r_disp_blank <= r_shadow_blank;
          r_pending    <= 1'b0;
        end
      end else if (load) begin
        r_shadow_val   <= value_in;
        r_shadow_blank <= blank_in;
        r_pending      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random loads/resets against a
// time-based reference model (slot and frame position derived from cycles since reset).
module tb_seven_seg_scan;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    seg_digit;
  logic [3:0]    an_out;
  logic          pending;
  logic          frame_done;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int          m_t;
  logic [15:0] m_sv, m_dv;
  logic [3:0]  m_sb, m_db;
  bit          m_pend;
  bit          m_valid = 0;

  seven_seg_scan #(.NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_in(blank_in),
    .seg_digit(seg_digit), .an_out(an_out), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h want=%h", tag, m_t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int          idx, pos;
    logic [3:0]  e_an;
    logic [15:0] sh;
    if (!m_valid) return;
    idx = (m_t / SLOT) % ND;
    pos = m_t % SLOT;
    sh  = m_dv >> (4 * idx);
    e_an = 4'hF;
    if (pos >= GUARD && !m_db[idx]) e_an[idx] = 1'b0;
    chk("seg", seg_digit, sh[3:0]);
    chk("an", an_out, e_an);
    chk("pend", pending, m_pend);
    chk("fd", frame_done, (m_t % FRAME) == FRAME - 1);
  endtask

  task automatic model_step(input bit ld, input logic [15:0] v, input logic [3:0] b, input bit r);
    if (r) begin
      m_t = 0; m_sv = '0; m_sb = '0; m_dv = '0; m_db = 4'hF; m_pend = 0; m_valid = 1;
      return;
    end
    if ((m_t % FRAME) == FRAME - 1) begin
      if (ld) begin
        m_dv = v; m_db = b; m_sv = v; m_sb = b; m_pend = 0;
      end else if (m_pend) begin
        m_dv = m_sv; m_db = m_sb; m_pend = 0;
      end
    end else if (ld) begin
      m_sv = v; m_sb = b; m_pend = 1;
    end
    m_t++;
  endtask

  // check the current cycle, apply inputs, advance one clock
  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] b, input bit r);
    check_outputs();
    load = ld; value_in = v; blank_in = b; rst = r;
    @(posedge clk);
    #1;
    model_step(ld, v, b, r);
    load = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    cycle(0, '0, '0, 1);
    cycle(0, '0, '0, 1);
    chk("rst_an", an_out, 4'hF);
    chk("rst_seg", seg_digit, 4'h0);
    chk("rst_pend", pending, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
  endtask

  initial begin
    // 1: idle after reset
    do_reset();
    for (int c = 0; c < 64; c++) begin
      chk("s1_an", an_out, 4'hF);
      chk("s1_pend", pending, 1'b0);
      if (m_t == 31 || m_t == 63) chk("s1_fd", frame_done, 1'b1);
      cycle(0, '0, '0, 0);
    end

    // 2: single load mid-frame
    do_reset();
    for (int c = 0; c < 64; c++) begin
      if (m_t >= 6 && m_t <= 31) chk("s2_pend_hi", pending, 1'b1);
      if (m_t == 32) chk("s2_pend_lo", pending, 1'b0);
      if (m_t >= 32 && m_t <= 39) chk("s2_seg0", seg_digit, 4'h1);
      if (m_t >= 34 && m_t <= 39) chk("s2_an0", an_out, 4'b1110);
      if (m_t >= 32 && m_t <= 33) chk("s2_guard0", an_out, 4'b1111);
      if (m_t >= 40 && m_t <= 47) chk("s2_seg1", seg_digit, 4'h2);
      if (m_t >= 42 && m_t <= 47) chk("s2_an1", an_out, 4'b1101);
      cycle(m_t == 5, 16'h4321, 4'h0, 0);
    end

    // 3: blanked digit 2
    do_reset();
    for (int c = 0; c < 72; c++) begin
      chk("s3_an2", an_out[2], 1'b1);
      if (m_t >= 32) chk("s3_seg", seg_digit, (m_t / SLOT) % ND == 0 ? 4'hD :
                                               (m_t / SLOT) % ND == 1 ? 4'hC :
                                               (m_t / SLOT) % ND == 2 ? 4'hB : 4'hA);
      cycle(m_t == 0, 16'hABCD, 4'b0100, 0);
    end

    // 4: last write wins
    do_reset();
    for (int c = 0; c < 64; c++) begin
      if (m_t >= 32) chk("s4_seg", seg_digit, 4'h2);
      cycle(m_t == 10 || m_t == 20, (m_t == 10) ? 16'h1111 : 16'h2222, 4'h0, 0);
    end

    // 5: load exactly on the boundary
    do_reset();
    for (int c = 0; c < 64; c++) begin
      chk("s5_pend", pending, 1'b0);
      if (m_t >= 32) chk("s5_seg", seg_digit, 4'h5);
      cycle(m_t == 31, 16'h5555, 4'h0, 0);
    end

    // 6: reset mid-slot after a commit
    do_reset();
    while (m_t < 50) cycle(m_t == 3, 16'h9876, 4'h0, 0);
    chk("s6_pre_seg", seg_digit, 4'h8);
    cycle(0, '0, '0, 1);
    chk("s6_an", an_out, 4'hF);
    chk("s6_seg", seg_digit, 4'h0);
    chk("s6_pend", pending, 1'b0);
    for (int c = 0; c < 40; c++) begin
      chk("s6_dark", an_out, 4'hF);
      cycle(0, '0, '0, 0);
    end

    // 7: random loads and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit          ld, r;
      logic [15:0] v;
      logic [3:0]  b;
      ld = ($urandom_range(0, 7) == 0) || ((m_t % FRAME) == FRAME - 1 && $urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 399) == 0);
      v  = 16'($urandom);
      b  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cycle(ld, v, b, r);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It sequences one shared `seven_seg_num` decoder across NUM_DIGITS digits. Each slot it selects one 4-bit nibble to feed the decoder and drives the matching active-low anode. Host values are loaded through a shadow register and committed only at frame boundaries, so the display never tears.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; minimum 2.
- SLOT_CYCLES, 50000, clock cycles per digit slot; minimum 2.
- GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off (anti-ghosting); must satisfy 0 <= GUARD_CYCLES < SLOT_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle request to capture value_in and blank_in into the shadow register.
- value_in  in  4*NUM_DIGITS  digit nibbles; digit 0 is bits [3:0].
- blank_in  in  NUM_DIGITS  per-digit blank; 1 means the anode is never enabled.
- seg_digit  out  4  nibble of the current digit; feeds the decoder's seg_in.
- an_out  out  NUM_DIGITS  anode enables, active-low (0 means on).
- pending  out  1  shadow holds data not yet committed.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
State:
- slot counter `cnt` (0..SLOT_CYCLES-1).
- digit index `idx` (0..NUM_DIGITS-1).
- shadow value/blank registers.
- display value/blank registers.
- `pending` flag.

Counter rules:
- `cnt` increments every cycle.
- At SLOT_CYCLES-1, `cnt` wraps to 0 and `idx` advances.
- `idx` wraps from NUM_DIGITS-1 to 0.

Frame boundary:
- Defined as the cycle where cnt == SLOT_CYCLES-1 and idx == NUM_DIGITS-1.
- frame_done is 1 in exactly that cycle.

Output decode (combinational from registered state):
- seg_digit = display nibble[idx].
- an_out[k] = 0 only when k == idx, cnt >= GUARD_CYCLES, and display blank[k] == 0. All other anode bits are 1.
- At most one anode bit is 0 at any time.

Load and commit:
- load=1: shadow <= {value_in, blank_in} and pending <= 1. A later load before commit overwrites the shadow (last write wins).
- Frame boundary with pending=1 and load=0: display <= shadow, pending <= 0.
- Frame boundary with load=1 (regardless of pending): display <= {value_in, blank_in} directly, shadow <= the same, pending <= 0.
- Frame boundary with pending=0 and load=0: display is unchanged.

Reset:
- cnt=0, idx=0, shadow=0, display value=0, display blank=all ones, pending=0.
- Output consequences: an_out = all ones, seg_digit = 0, frame_done = 0. The display stays dark until the first commit.
- A reset mid-frame discards any pending shadow data and restarts the scan at digit 0, cnt 0, in the next cycle.

## Timing
- Frame length: NUM_DIGITS*SLOT_CYCLES cycles.
- Per slot: anode on for SLOT_CYCLES-GUARD_CYCLES cycles.
- If GUARD_CYCLES = 0, the anode is on for the whole slot and changes to the next digit with no dead cycle.
- seg_digit changes in the same cycle as idx, during the guard period (when GUARD_CYCLES > 0).
- Commit latency: data loaded at cycle t is visible from the first cycle of the next frame. This ranges from 1 cycle (load on the boundary) up to one full frame.
- pending rises the cycle after load. It falls the cycle after the committing boundary.
- load during reset is ignored.

## Test plan
Use SLOT_CYCLES=8, GUARD_CYCLES=2, NUM_DIGITS=4.

1. Reset, then idle 64 cycles.
   - an_out stays 4'b1111.
   - frame_done pulses at cycles 31 and 63 after reset release.
   - pending stays 0.
2. load value_in=16'h4321, blank_in=0 at cycle 5.
   - pending=1 from cycle 6 until the boundary at cycle 31.
   - From cycle 32: digit 0 has seg_digit=1, with an_out=4'b1110 during cycles 34-39.
   - Digit 1 has seg_digit=2, with an_out=4'b1101 during cycles 42-47.
3. blank_in=4'b0100 with value 16'hABCD committed.
   - an_out[2] is never 0.
   - seg_digit still cycles D, C, B, A.
4. load 16'h1111 at cycle 10, then 16'h2222 at cycle 20.
   - The commit at cycle 31 shows 2222; 1111 is never displayed.
5. load 16'h5555 exactly on the boundary cycle 31.
   - Display shows 5 from cycle 32.
   - pending never rises.
6. Commit 16'h9876, then assert rst at cycle 50 mid-slot.
   - Next cycle: an_out=4'b1111, seg_digit=0, pending=0.
   - Scan restarts at idx 0.
